// File: rtl/fila_pkg.sv
// Shared sizing for the RAM-backed FIFO controller.
package fila_pkg;

    localparam int unsigned FILA_LARGURA = 16;  // data word width
    localparam int unsigned FILA_PROF    = 8;   // RAM depth in words
    localparam int unsigned FILA_PTR_W   = 3;   // RAM address / pointer width
    localparam int unsigned FILA_CONT_W  = 4;   // occupancy and total-count width

endpackage

// File: rtl/fila_ponteiros.sv
// Write/read pointers and RAM occupancy for the FIFO; pointers wrap 7->0.
module fila_ponteiros
    import fila_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   escreve_i,
    input  logic                   le_i,
    output logic [FILA_PTR_W-1:0]  wp_o,
    output logic [FILA_PTR_W-1:0]  rp_o,
    output logic [FILA_CONT_W-1:0] ocup_o
);

    logic [FILA_PTR_W-1:0]  wp_q, wp_d;
    logic [FILA_PTR_W-1:0]  rp_q, rp_d;
    logic [FILA_CONT_W-1:0] ocup_q, ocup_d;

    // Next pointer/occupancy values from this cycle's RAM access
    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        ocup_d = ocup_q;
        if (escreve_i) begin
            wp_d = wp_q + FILA_PTR_W'(1);
        end
        if (le_i) begin
            rp_d = rp_q + FILA_PTR_W'(1);
        end
        case ({escreve_i, le_i})
            2'b10:   ocup_d = ocup_q + FILA_CONT_W'(1);
            2'b01:   ocup_d = ocup_q - FILA_CONT_W'(1);
            default: ocup_d = ocup_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            ocup_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            ocup_q <= ocup_d;
        end
    end

    assign wp_o   = wp_q;
    assign rp_o   = rp_q;
    assign ocup_o = ocup_q;

endmodule

// File: rtl/fila_ram_ctrl.sv
// FIFO controller over a single-port 8x16 combinational-read RAM with a
// registered head word. Optional macro FILA_RAM_CTRL_BYPASS_EN lets a push
// into an empty FIFO load the head register directly, skipping the RAM.
module fila_ram_ctrl
    import fila_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [FILA_LARGURA-1:0] push_dados,
    output logic                    pop_valid,
    input  logic                    pop_ready,
    output logic [FILA_LARGURA-1:0] pop_dados,
    output logic [FILA_CONT_W-1:0]  contagem,
    output logic                    cheio,
    output logic                    vazio,
    output logic                    ram_enable,
    output logic                    ram_write_enable,
    output logic [FILA_PTR_W-1:0]   ram_addr,
    output logic [FILA_LARGURA-1:0] ram_dados_in,
    input  logic [FILA_LARGURA-1:0] ram_dados_out
);

    logic [FILA_PTR_W-1:0]   wp, rp;
    logic [FILA_CONT_W-1:0]  ocup;
    logic                    ram_vazia, leitura, aceita, bypass, escrita;
    logic                    pop_valid_q, pop_valid_d;
    logic [FILA_LARGURA-1:0] pop_dados_q, pop_dados_d;

    fila_ponteiros u_ponteiros (
        .clk       (clk),
        .rst_n     (rst_n),
        .escreve_i (escrita),
        .le_i      (leitura),
        .wp_o      (wp),
        .rp_o      (rp),
        .ocup_o    (ocup)
    );

    // Arbitration: a head refill from RAM wins the single port over a push
    assign ram_vazia  = (ocup == '0);
    assign leitura    = (!pop_valid_q || pop_ready) && !ram_vazia;
    assign cheio      = (ocup == FILA_CONT_W'(FILA_PROF));
    assign push_ready = !cheio && !leitura;
    assign aceita     = push_valid && push_ready;
`ifdef FILA_RAM_CTRL_BYPASS_EN
    assign bypass     = aceita && ram_vazia && (!pop_valid_q || pop_ready);
`else
    assign bypass     = 1'b0;
`endif
    assign escrita    = aceita && !bypass;

    // RAM port; held idle while reset is asserted
    assign ram_enable       = rst_n && (leitura || escrita);
    assign ram_write_enable = rst_n && escrita;
    assign ram_addr         = leitura ? rp : wp;
    assign ram_dados_in     = push_dados;

    // Head register next state: refill from RAM, bypass load, or drain
    always_comb begin
        pop_valid_d = pop_valid_q;
        pop_dados_d = pop_dados_q;
        if (leitura) begin
            pop_valid_d = 1'b1;
            pop_dados_d = ram_dados_out;
        end else if (bypass) begin
            pop_valid_d = 1'b1;
            pop_dados_d = push_dados;
        end else if (pop_valid_q && pop_ready) begin
            pop_valid_d = 1'b0;
        end
    end

    // Head register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid_q <= 1'b0;
            pop_dados_q <= '0;
        end else begin
            pop_valid_q <= pop_valid_d;
            pop_dados_q <= pop_dados_d;
        end
    end

    assign pop_valid = pop_valid_q;
    assign pop_dados = pop_dados_q;
    assign contagem  = ocup + FILA_CONT_W'(pop_valid_q);
    assign vazio     = (contagem == '0);

endmodule

// File: tb/tb_fila_ram_ctrl.sv
// Bench for fila_ram_ctrl: behavioural 8x16 RAM, queue reference model,
// directed scenarios followed by a randomized push/pop phase.
module tb_fila_ram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_dados;
    logic        pop_valid;
    logic        pop_ready;
    logic [15:0] pop_dados;
    logic [3:0]  contagem;
    logic        cheio;
    logic        vazio;
    logic        ram_enable;
    logic        ram_write_enable;
    logic [2:0]  ram_addr;
    logic [15:0] ram_dados_in;
    logic [15:0] ram_dados_out;

    int n_checks = 0;
    int n_errors = 0;

    fila_ram_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_dados       (push_dados),
        .pop_valid        (pop_valid),
        .pop_ready        (pop_ready),
        .pop_dados        (pop_dados),
        .contagem         (contagem),
        .cheio            (cheio),
        .vazio            (vazio),
        .ram_enable       (ram_enable),
        .ram_write_enable (ram_write_enable),
        .ram_addr         (ram_addr),
        .ram_dados_in     (ram_dados_in),
        .ram_dados_out    (ram_dados_out)
    );

    // Behavioural single-port RAM: combinational read, synchronous write
    logic [15:0] mem [8];
    always_ff @(posedge clk) begin
        if (ram_enable && ram_write_enable) mem[ram_addr] <= ram_dados_in;
    end
    assign ram_dados_out = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: words accepted and not yet handed to the consumer
    logic [15:0] mdl_q [$];
    logic        exp_pv;
    int          mdl_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_q.delete();
            exp_pv = 1'b0;
        end else begin
            if (exp_pv) chk("pv_latencia", 32'(pop_valid), 32'd1);
            chk("contagem", 32'(contagem), 32'(mdl_q.size()));
            chk("vazio", 32'(vazio), 32'(mdl_q.size() == 0));
            chk("cheio", 32'(cheio), 32'((mdl_q.size() - int'(pop_valid)) == 8));
            if (ram_enable && ram_write_enable)
                chk("ram_overflow", 32'((mdl_q.size() - int'(pop_valid)) < 8), 32'd1);
            mdl_n = mdl_q.size();
            if (pop_valid && pop_ready) begin
                if (mdl_n == 0) chk("pop_sem_dado", 32'(pop_valid), 32'd0);
                else begin
                    chk("pop_dados", 32'(pop_dados), 32'(mdl_q.pop_front()));
                    mdl_n--;
                end
            end
            // Any word still held after this edge must be presented next cycle
            exp_pv = (mdl_n > 0);
            if (push_valid && push_ready) mdl_q.push_back(push_dados);
        end
    end

    task automatic push_word(input logic [15:0] d, input int budget);
        int k;
        push_valid = 1'b1;
        push_dados = d;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (push_ready) break;
        end
        chk("push_timeout", 32'(k < budget), 32'd1);
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic drenar(input int budget);
        int k;
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (vazio) break;
        end
        chk("drenar_timeout", 32'(k < budget), 32'd1);
        @(posedge clk); #1;
        pop_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   k;
        rst_n      = 1'b0;
        push_valid = 1'b1;
        push_dados = 16'h1234;
        pop_ready  = 1'b0;

        // Reset state, with a push offered to show the RAM port stays idle
        #12;
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_contagem", 32'(contagem), 32'd0);
        chk("rst_vazio", 32'(vazio), 32'd1);
        chk("rst_cheio", 32'(cheio), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_pop_dados", 32'(pop_dados), 32'h0000);
        chk("rst_ram_en", 32'(ram_enable), 32'd0);
        chk("rst_ram_we", 32'(ram_write_enable), 32'd0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        push_valid = 1'b0;
        @(posedge clk); #1;

        // Single push of A001 with consumer stalled
        push_valid = 1'b1;
        push_dados = 16'hA001;
        @(negedge clk);
`ifdef FILA_RAM_CTRL_BYPASS_EN
        chk("a001_ram_en", 32'(ram_enable), 32'd0);
        @(posedge clk); #1;
        push_valid = 1'b0;
        @(negedge clk);
        chk("a001_pv", 32'(pop_valid), 32'd1);
        chk("a001_dados", 32'(pop_dados), 32'hA001);
        chk("a001_cont", 32'(contagem), 32'd1);
        chk("a001_ram_en2", 32'(ram_enable), 32'd0);
`else
        chk("a001_wr_en", 32'(ram_enable), 32'd1);
        chk("a001_wr_we", 32'(ram_write_enable), 32'd1);
        chk("a001_wr_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        push_valid = 1'b0;
        @(negedge clk);
        chk("a001_pv_cedo", 32'(pop_valid), 32'd0);
        chk("a001_rd_en", 32'(ram_enable), 32'd1);
        chk("a001_rd_we", 32'(ram_write_enable), 32'd0);
        chk("a001_rd_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("a001_pv", 32'(pop_valid), 32'd1);
        chk("a001_dados", 32'(pop_dados), 32'hA001);
        chk("a001_cont", 32'(contagem), 32'd1);
`endif
        @(posedge clk); #1;
        pop_ready = 1'b1;
        @(posedge clk); #1;
        pop_ready = 1'b0;

        // Fill: nine words make the FIFO full, a tenth stalls
        for (int i = 1; i <= 9; i++) push_word(16'(i), 6);
        @(negedge clk);
        chk("cheio_9", 32'(cheio), 32'd1);
        chk("push_ready_9", 32'(push_ready), 32'd0);
        chk("contagem_9", 32'(contagem), 32'd9);
        @(posedge clk); #1;
        push_valid = 1'b1;
        push_dados = 16'h000A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("decimo_stall", 32'(push_ready), 32'd0);
        end
        @(posedge clk); #1;
        push_valid = 1'b0;

        // Drain full FIFO: one word per cycle in order
        pop_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("drain_pv", 32'(pop_valid), 32'd1);
            chk("drain_dados", 32'(pop_dados), 32'(i));
        end
        @(posedge clk); #1;
        pop_ready = 1'b0;
        @(negedge clk);
        chk("drain_vazio", 32'(vazio), 32'd1);
        chk("drain_cont", 32'(contagem), 32'd0);
        @(posedge clk); #1;

        // Streaming push and pop across pointer wrap
        pop_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_word(16'h3100 + 16'(i), 6);
        drenar(30);

        // Reset in the middle of a stream holding five words
        pop_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(16'h5000 + 16'(i), 6);
        @(negedge clk);
        chk("pre_rst_cont", 32'(contagem), 32'd5);
        #2;
        push_valid = 1'b1;
        push_dados = 16'hDEAD;
        rst_n      = 1'b0;
        #1;
        chk("mid_rst_pv", 32'(pop_valid), 32'd0);
        chk("mid_rst_cont", 32'(contagem), 32'd0);
        chk("mid_rst_ram_en", 32'(ram_enable), 32'd0);
        chk("mid_rst_vazio", 32'(vazio), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        push_valid = 1'b0;
        @(posedge clk); #1;
        push_valid = 1'b1;
        push_dados = 16'hBEEF;
        @(negedge clk);
        chk("pos_rst_ready", 32'(push_ready), 32'd1);
`ifndef FILA_RAM_CTRL_BYPASS_EN
        chk("pos_rst_addr", 32'(ram_addr), 32'd0);
        chk("pos_rst_we", 32'(ram_write_enable), 32'd1);
`endif
        @(posedge clk); #1;
        push_valid = 1'b0;
        for (k = 0; k < 5; k++) begin
            @(negedge clk);
            if (pop_valid) break;
        end
        chk("pos_rst_pv", 32'(pop_valid), 32'd1);
        chk("pos_rst_dados", 32'(pop_dados), 32'hBEEF);
        @(posedge clk); #1;
        drenar(10);

        // Randomized traffic; a stalled push holds its data until accepted
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = push_valid && push_ready;
            @(posedge clk); #1;
            if (acc || !push_valid) begin
                push_valid = ($urandom_range(0, 3) != 0);
                push_dados = 16'($urandom);
            end
            pop_ready = ($urandom_range(0, 2) != 0);
        end
        drenar(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
